// File: rtl/xs2p_pkg.sv
// Shared helpers for the xs2p_mc serial-to-parallel packer.
package xs2p_pkg;

    // Ceiling log2, used to size the word-count fields.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Slot that word k of a group lands in, given the word-order selection.
    function automatic int slot(input int k, input bit msb_first, input int npar);
        return msb_first ? (npar - 1 - k) : k;
    endfunction

endpackage

// File: rtl/xs2p_lane.sv
// One channel's group accumulator: NPAR words of BWID bits.
// grp presents the accumulator with the current word merged in, so a group
// that completes on this beat can be pushed without waiting a cycle.
module xs2p_lane #(
    parameter int BWID = 8,
    parameter int NPAR = 4,
    parameter int CW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_slot,
    input  logic [BWID-1:0]      wr_data,
    input  logic                 merge,
    input  logic                 clr,
    output logic [NPAR*BWID-1:0] grp
);

    logic [NPAR*BWID-1:0] acc;

    // Accumulator storage: a retained write wins over clear so a trigger word
    // survives the push of the previous partial group.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            for (int j = 0; j < NPAR; j++) begin
                if (wr_en && (wr_slot == CW'(j))) begin
                    acc[j*BWID +: BWID] <= wr_data;
                end else if (clr) begin
                    acc[j*BWID +: BWID] <= '0;
                end
            end
        end
    end

    // Group as it would be pushed this cycle, including the incoming word.
    always_comb begin
        grp = acc;
        for (int j = 0; j < NPAR; j++) begin
            if (merge && (wr_slot == CW'(j))) begin
                grp[j*BWID +: BWID] = wr_data;
            end
        end
    end

endmodule

// File: rtl/xs2p_mc.sv
// Multi-channel serial-to-parallel packer. Collects NPAR words per channel
// into one group, with trigger realignment, flush and short-group counts.
//
// acc_cnt | meaning
// --------+-------------------------------------------------
// 0       | accumulator empty, next accepted word is word 0
// 1..N-1  | that many words held; acc_trig tags word 0
module xs2p_mc import xs2p_pkg::*; #(
    parameter int BWID      = 8,
    parameter int NPAR      = 4,
    parameter int NCH       = 1,
    parameter int MSB_FIRST = 0,
    parameter int CW        = clog2(NPAR + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*BWID-1:0]       s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_trig,
    input  logic                      s_flush,
    output logic [NCH*NPAR*BWID-1:0]  m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_trig,
    output logic [CW-1:0]             m_cnt
);

    logic [CW-1:0]            acc_cnt;
    logic                     acc_trig;
    logic [CW-1:0]            acc_cnt_nxt;
    logic                     acc_trig_nxt;

    logic                     accept;
    logic                     split;
    logic                     full;
    logic                     flush_ok;
    logic                     push;
    logic [CW-1:0]            push_cnt;
    logic                     push_trig;
    logic                     keep;
    logic                     merge;
    logic [CW-1:0]            wr_slot;
    logic [NCH*NPAR*BWID-1:0] grp_all;

    // The input side stalls only while a group is held and not being taken.
    assign s_ready = !m_valid || m_ready;

    // Accumulator control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= '0;
            acc_trig <= 1'b0;
        end else begin
            acc_cnt  <= acc_cnt_nxt;
            acc_trig <= acc_trig_nxt;
        end
    end

    // Next accumulator count and trigger tag.
    always_comb begin
        acc_cnt_nxt  = acc_cnt;
        acc_trig_nxt = acc_trig;
        if (split) begin
            acc_cnt_nxt  = CW'(1);
            acc_trig_nxt = 1'b1;
        end else if (push) begin
            acc_cnt_nxt  = '0;
            acc_trig_nxt = 1'b0;
        end else if (accept) begin
            acc_cnt_nxt = acc_cnt + CW'(1);
            if (acc_cnt == '0) begin
                acc_trig_nxt = s_trig;
            end
        end
    end

    // Beat decode: acceptance, split/full/flush pushes and lane controls.
    // A split pushes the old partial and keeps the trigger word as word 0,
    // so any flush on that beat is dropped.
    always_comb begin
        accept    = s_valid && s_ready;
        split     = accept && s_trig && (acc_cnt != '0);
        full      = accept && !split && (acc_cnt == CW'(NPAR - 1));
        flush_ok  = s_flush && s_ready && ((acc_cnt != '0) || accept) && !split;
        push      = split || full || flush_ok;
        push_cnt  = (accept && !split) ? (acc_cnt + CW'(1)) : acc_cnt;
        push_trig = (acc_cnt == '0) ? (accept && s_trig) : acc_trig;
        wr_slot   = CW'(slot(split ? 0 : int'(acc_cnt), MSB_FIRST != 0, NPAR));
        keep      = accept && (split || !push);
        merge     = accept && !split;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        xs2p_lane #(
            .BWID (BWID),
            .NPAR (NPAR),
            .CW   (CW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (keep),
            .wr_slot (wr_slot),
            .wr_data (s_data[c*BWID +: BWID]),
            .merge   (merge),
            .clr     (push),
            .grp     (grp_all[c*NPAR*BWID +: NPAR*BWID])
        );
    end

    // Output register: load on push, otherwise drop valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_trig  <= 1'b0;
            m_cnt   <= '0;
        end else if (push) begin
            m_valid <= 1'b1;
            m_data  <= grp_all;
            m_trig  <= push_trig;
            m_cnt   <= push_cnt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xs2p_mc.sv
// Bench for xs2p_mc: LSB-first and MSB-first instances share one stimulus
// stream and are checked against a word-list model of the packing rules.
module tb_xs2p_mc;

    localparam int BWID = 8;
    localparam int NPAR = 4;
    localparam int NCH  = 2;
    localparam int GW   = NCH * NPAR * BWID;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH*BWID-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_trig = 1'b0;
    logic                s_flush = 1'b0;
    logic                m_ready = 1'b0;

    logic                s_ready0, s_ready1;
    logic [GW-1:0]       m_data0, m_data1;
    logic                m_valid0, m_valid1;
    logic                m_trig0, m_trig1;
    logic [2:0]          m_cnt0, m_cnt1;

    always #5 clk = ~clk;

    xs2p_mc #(.BWID(BWID), .NPAR(NPAR), .NCH(NCH), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .s_trig(s_trig), .s_flush(s_flush),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .m_trig(m_trig0), .m_cnt(m_cnt0)
    );

    xs2p_mc #(.BWID(BWID), .NPAR(NPAR), .NCH(NCH), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .s_trig(s_trig), .s_flush(s_flush),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .m_trig(m_trig1), .m_cnt(m_cnt1)
    );

    // Reference model: words of the current group, its trigger tag, and the
    // expected contents of the single output register.
    logic [NCH*BWID-1:0] words[$];
    bit                  gtrig;
    bit                  exp_valid;
    logic [GW-1:0]       exp_d0, exp_d1;
    bit                  exp_trig;
    int                  exp_cnt;
    bit                  pushed;
    bit                  last_acc;
    int                  total = 0;
    int                  bad = 0;

    function automatic logic [GW-1:0] pack(bit msb);
        logic [GW-1:0] r;
        r = '0;
        for (int k = 0; k < words.size(); k++) begin
            int s;
            s = msb ? (NPAR - 1 - k) : k;
            for (int c = 0; c < NCH; c++) begin
                r[c*NPAR*BWID + s*BWID +: BWID] = words[k][c*BWID +: BWID];
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic emit();
        exp_d0   = pack(1'b0);
        exp_d1   = pack(1'b1);
        exp_trig = gtrig;
        exp_cnt  = words.size();
        words.delete();
        gtrig    = 1'b0;
        pushed   = 1'b1;
    endtask

    task automatic check_out();
        chk("m_valid0", 64'(m_valid0), 64'(exp_valid));
        chk("m_valid1", 64'(m_valid1), 64'(exp_valid));
        if (exp_valid) begin
            chk("m_data0", m_data0, exp_d0);
            chk("m_data1", m_data1, exp_d1);
            chk("m_trig0", 64'(m_trig0), 64'(exp_trig));
            chk("m_trig1", 64'(m_trig1), 64'(exp_trig));
            chk("m_cnt0", 64'(m_cnt0), 64'(exp_cnt));
            chk("m_cnt1", 64'(m_cnt1), 64'(exp_cnt));
        end
    endtask

    // One clock of stimulus: drive, check ready, advance the model, check outputs.
    task automatic step(bit v, logic [NCH*BWID-1:0] d, bit t, bit f, bit mr);
        bit rdy;
        s_valid = v;
        s_data  = d;
        s_trig  = t;
        s_flush = f;
        m_ready = mr;
        #1;
        rdy = !exp_valid || mr;
        chk("s_ready0", 64'(s_ready0), 64'(rdy));
        chk("s_ready1", 64'(s_ready1), 64'(rdy));
        pushed   = 1'b0;
        last_acc = v && rdy;
        if (last_acc && t && (words.size() > 0)) begin
            emit();
            words.push_back(d);
            gtrig = 1'b1;
        end else begin
            if (last_acc) begin
                if (words.size() == 0) gtrig = t;
                words.push_back(d);
            end
            if ((words.size() == NPAR) || (f && rdy && (words.size() > 0))) emit();
        end
        if (pushed) exp_valid = 1'b1;
        else if (mr) exp_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_trig  = 1'b0;
        s_flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        words.delete();
        gtrig     = 1'b0;
        exp_valid = 1'b0;
        chk("rst_valid0", 64'(m_valid0), 64'd0);
        chk("rst_valid1", 64'(m_valid1), 64'd0);
        chk("rst_data0", m_data0, 64'd0);
        chk("rst_data1", m_data1, 64'd0);
        chk("rst_trig0", 64'(m_trig0), 64'd0);
        chk("rst_cnt0", 64'(m_cnt0), 64'd0);
        chk("rst_sready0", 64'(s_ready0), 64'd1);
        chk("rst_sready1", 64'(s_ready1), 64'd1);
    endtask

    initial begin
        logic [7:0] seq;

        // Reset state
        do_reset();

        // Basic full group, both word orders
        step(1, 16'h1101, 0, 0, 1);
        step(1, 16'h1202, 0, 0, 1);
        step(1, 16'h1303, 0, 0, 1);
        step(1, 16'h1404, 0, 0, 1);
        chk("tp1_data0", m_data0, 64'h14131211_04030201);
        chk("tp1_data1", m_data1, 64'h11121314_01020304);
        chk("tp1_cnt", 64'(m_cnt0), 64'd4);

        // Trigger split: A1,A2 then B1 with trigger
        step(1, 16'hC1A1, 0, 0, 1);
        step(1, 16'hC2A2, 0, 0, 1);
        step(1, 16'hD1B1, 1, 0, 1);
        chk("split_data0", m_data0, 64'h0000C2C1_0000A2A1);
        chk("split_cnt", 64'(m_cnt0), 64'd2);
        chk("split_trig", 64'(m_trig0), 64'd0);
        step(1, 16'hD2B2, 0, 0, 1);
        step(1, 16'hD3B3, 0, 0, 1);
        step(1, 16'hD4B4, 0, 0, 1);
        chk("trig_data0", m_data0, 64'hD4D3D2D1_B4B3B2B1);
        chk("trig_flag", 64'(m_trig0), 64'd1);

        // Flush after three words, then flush on an empty accumulator
        step(1, 16'h4131, 0, 0, 1);
        step(1, 16'h4232, 0, 0, 1);
        step(1, 16'h4333, 0, 0, 1);
        step(0, 16'h0000, 0, 1, 1);
        chk("flush_cnt", 64'(m_cnt0), 64'd3);
        chk("flush_top0", 64'(m_data0[31:24]), 64'd0);
        chk("flush_bot1", 64'(m_data1[7:0]), 64'd0);
        step(0, 16'h0000, 0, 1, 1);
        chk("flush_empty", 64'(m_valid0), 64'd0);

        // Backpressure: source holds its word until accepted
        seq = 8'h50;
        for (int i = 0; i < 10; i++) begin
            step(1, {seq + 8'h80, seq}, 0, 0, 0);
            if (last_acc) seq++;
        end
        chk("bp_sready", 64'(s_ready0), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step(1, {seq + 8'h80, seq}, 0, 0, 1);
            if (last_acc) seq++;
        end
        step(0, 16'h0000, 0, 1, 1);
        step(0, 16'h0000, 0, 0, 1);

        // Reset in the middle of a group
        step(1, 16'h6151, 0, 0, 1);
        step(1, 16'h6252, 0, 0, 1);
        do_reset();
        step(1, 16'h7161, 0, 0, 1);
        step(1, 16'h7262, 0, 0, 1);
        step(1, 16'h7363, 0, 0, 1);
        step(1, 16'h7464, 0, 0, 1);
        chk("post_rst_cnt", 64'(m_cnt0), 64'd4);
        chk("post_rst_data0", m_data0, 64'h74737271_64636261);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 16'h0000, 0, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
